// File: rtl/pipeline_hazard_scoreboard.sv
// Hazard controller for a 5-stage pipeline: tracks in-flight destination tags,
// stalls ID on RAW hazards, flushes on WB redirects, keeps counters and a watchdog.
module pipeline_hazard_scoreboard #(
    parameter int WB_BYPASS   = 0,
    parameter int CNT_W       = 32,
    parameter int STALL_LIMIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_writes_rd,
    input  logic             wb_redirect,
    output logic             stall,
    output logic             bubble_ex,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             deadlock_err
);

    localparam int RUN_W = $clog2(STALL_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STALL_LIMIT);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STALL_LIMIT - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STALLED,
        ST_FLUSHING
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } tag_t;

    state_t           state;
    tag_t             ex_tag;
    tag_t             mem_tag;
    tag_t             wb_tag;
    logic [RUN_W-1:0] run_len;

    logic id_live;
    logic hit_rs1;
    logic hit_rs2;
    logic issue;

    function automatic logic tag_match(input tag_t t, input logic [4:0] r);
        return t.valid && (t.rd == r);
    endfunction

    // With write-through in WB the register file already holds the value,
    // so only EX and MEM tags can block a reader.
    function automatic logic hit(input logic [4:0] r, input tag_t t_ex,
                                 input tag_t t_mem, input tag_t t_wb);
        logic wb_hit;
        wb_hit = (WB_BYPASS == 0) && tag_match(t_wb, r);
        return (r != 5'd0) && (tag_match(t_ex, r) || tag_match(t_mem, r) || wb_hit);
    endfunction

    always_comb begin
        // The IF/ID contents just after a flush are squashed garbage.
        id_live   = id_valid && (state != ST_FLUSHING);
        hit_rs1   = id_uses_rs1 && hit(id_rs1, ex_tag, mem_tag, wb_tag);
        hit_rs2   = id_uses_rs2 && hit(id_rs2, ex_tag, mem_tag, wb_tag);
        stall     = !rst && id_live && !wb_redirect && (hit_rs1 || hit_rs2);
        bubble_ex = stall;
        flush     = !rst && wb_redirect;
        issue     = id_live && id_writes_rd && (id_rd != 5'd0) && !stall && !wb_redirect;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            ex_tag       <= '0;
            mem_tag      <= '0;
            wb_tag       <= '0;
            run_len      <= '0;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
            deadlock_err <= 1'b0;
        end else begin
            if (wb_redirect) begin
                ex_tag  <= '0;
                mem_tag <= '0;
                wb_tag  <= '0;
            end else begin
                wb_tag  <= mem_tag;
                mem_tag <= ex_tag;
                ex_tag  <= issue ? tag_t'{valid: 1'b1, rd: id_rd} : '0;
            end

            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (wb_redirect && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end

            // Watchdog trips on the stall cycle that brings the run to the limit.
            if (stall) begin
                if (run_len != RUN_MAX) begin
                    run_len <= run_len + RUN_W'(1);
                end
                if (run_len >= RUN_LAST) begin
                    deadlock_err <= 1'b1;
                end
            end else begin
                run_len <= '0;
            end

            if (wb_redirect) begin
                state <= ST_FLUSHING;
            end else if (stall) begin
                state <= ST_STALLED;
            end else begin
                state <= ST_RUN;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// Bench: two scoreboard instances (WB_BYPASS 0 and 1) share one stimulus stream
// and are compared each cycle against a register-age reference model.
module tb_pipeline_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] id_rd;
    logic       id_writes_rd;
    logic       wb_redirect;

    logic       s0, b0, f0, e0;
    logic [3:0] sc0, fc0;
    logic       s1, b1, f1, e1;
    logic [7:0] sc1, fc1;

    always #5 clk = ~clk;

    pipeline_hazard_scoreboard #(.WB_BYPASS(0), .CNT_W(4), .STALL_LIMIT(3)) u_dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_writes_rd(id_writes_rd), .wb_redirect(wb_redirect), .stall(s0),
        .bubble_ex(b0), .flush(f0), .stall_cnt(sc0), .flush_cnt(fc0), .deadlock_err(e0)
    );

    pipeline_hazard_scoreboard #(.WB_BYPASS(1), .CNT_W(8), .STALL_LIMIT(3)) u_dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_writes_rd(id_writes_rd), .wb_redirect(wb_redirect), .stall(s1),
        .bubble_ex(b1), .flush(f1), .stall_cnt(sc1), .flush_cnt(fc1), .deadlock_err(e1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: cycles since the most recent issued write to each register.
    localparam int BIG   = 1000;
    localparam int LIMIT = 3;
    int age[2][32];
    int scnt[2];
    int fcnt[2];
    int run[2];
    bit err[2];
    bit fl[2];
    bit obs0, obs1;

    function automatic int win(input int i);
        return (i == 0) ? 3 : 2;
    endfunction

    function automatic int cmax(input int i);
        return (i == 0) ? 15 : 255;
    endfunction

    function automatic bit mhit(input int i, input logic [4:0] r);
        return (r != 5'd0) && (age[i][r] < win(i));
    endfunction

    function automatic bit exp_stall(input int i);
        return !rst && !fl[i] && id_valid && !wb_redirect &&
               ((id_uses_rs1 && mhit(i, id_rs1)) || (id_uses_rs2 && mhit(i, id_rs2)));
    endfunction

    task automatic model_edge(input int i, input bit st);
        if (rst) begin
            for (int r = 0; r < 32; r++) age[i][r] = BIG;
            scnt[i] = 0; fcnt[i] = 0; run[i] = 0; err[i] = 1'b0; fl[i] = 1'b0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (wb_redirect) age[i][r] = BIG;
                else if (age[i][r] < BIG) age[i][r]++;
            end
            if (!wb_redirect && !fl[i] && id_valid && id_writes_rd && id_rd != 5'd0 && !st)
                age[i][id_rd] = 0;
            if (st) begin
                if (scnt[i] < cmax(i)) scnt[i]++;
                if (run[i] < LIMIT) run[i]++;
                if (run[i] == LIMIT) err[i] = 1'b1;
            end else begin
                run[i] = 0;
            end
            if (wb_redirect && fcnt[i] < cmax(i)) fcnt[i]++;
            fl[i] = wb_redirect;
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [4:0] a, input logic [4:0] b,
                        input bit ua, input bit ub, input logic [4:0] d, input bit wd,
                        input bit rdir);
        bit x0, x1;
        rst = r; id_valid = v; id_rs1 = a; id_rs2 = b; id_uses_rs1 = ua; id_uses_rs2 = ub;
        id_rd = d; id_writes_rd = wd; wb_redirect = rdir;
        #2;
        x0 = exp_stall(0);
        x1 = exp_stall(1);
        check("stall0", 32'(s0), 32'(x0));
        check("bubble0", 32'(b0), 32'(x0));
        check("flush0", 32'(f0), 32'(!r && rdir));
        check("stall1", 32'(s1), 32'(x1));
        check("bubble1", 32'(b1), 32'(x1));
        check("flush1", 32'(f1), 32'(!r && rdir));
        obs0 = s0;
        obs1 = s1;
        @(posedge clk);
        model_edge(0, x0);
        model_edge(1, x1);
        #1;
        check("stall_cnt0", 32'(sc0), 32'(scnt[0]));
        check("flush_cnt0", 32'(fc0), 32'(fcnt[0]));
        check("deadlock0", 32'(e0), 32'(err[0]));
        check("stall_cnt1", 32'(sc1), 32'(scnt[1]));
        check("flush_cnt1", 32'(fc1), 32'(fcnt[1]));
        check("deadlock1", 32'(e1), 32'(err[1]));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic writer5();
        step(0, 1, 0, 0, 0, 0, 5'd5, 1, 0);
    endtask

    task automatic reader5(input bit r, input bit rdir);
        step(r, 1, 5'd5, 0, 1, 0, 0, 0, rdir);
    endtask

    int n0, n1;

    initial begin
        rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_rd = 0; id_writes_rd = 0; wb_redirect = 0;
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 32; r++) age[i][r] = BIG;
            scnt[i] = 0; fcnt[i] = 0; run[i] = 0; err[i] = 1'b0; fl[i] = 1'b0;
        end
        @(posedge clk);
        #1;

        // Reset with random inputs
        for (int k = 0; k < 2; k++)
            step(1, 1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                 5'($urandom), 1'($urandom), 1'($urandom));
        check("rst_stall_cnt", 32'(sc0), 0);
        check("rst_flush_cnt", 32'(fc0), 0);
        check("rst_deadlock", 32'(e0), 0);
        reader5(0, 0);
        check("first_reader_nostall", 32'(obs0), 0);

        // RAW hazard: 3 stalls without bypass, 2 with bypass
        idle();
        writer5();
        n0 = 0; n1 = 0;
        for (int k = 0; k < 4; k++) begin
            reader5(0, 0);
            n0 += int'(obs0);
            n1 += int'(obs1);
        end
        check("raw_stall_len0", 32'(n0), 3);
        check("raw_stall_len1", 32'(n1), 2);
        check("raw_stall_cnt0", 32'(sc0), 3);
        check("raw_stall_cnt1", 32'(sc1), 2);
        check("raw_watchdog0", 32'(e0), 1);
        check("raw_watchdog1", 32'(e1), 0);

        // x0 and unused sources never stall
        idle(); idle(); idle();
        step(0, 1, 0, 0, 0, 0, 5'd0, 1, 0);
        step(0, 1, 5'd0, 0, 1, 0, 0, 0, 0);
        check("x0_nostall", 32'(obs0), 0);
        writer5();
        step(0, 1, 0, 5'd5, 0, 0, 0, 0, 0);
        check("unused_rs2_nostall", 32'(obs0), 0);

        // Redirect in the middle of a stall
        idle(); idle(); idle();
        writer5();
        reader5(0, 0);
        check("redir_pre_stall", 32'(obs0), 1);
        reader5(0, 1);
        check("redir_stall_dropped", 32'(obs0), 0);
        check("redir_flush_cnt", 32'(fc0), 1);
        reader5(0, 0);
        reader5(0, 0);
        check("redir_after_nostall", 32'(obs0), 0);

        // Counter saturation with back-to-back dependent writers
        for (int k = 0; k < 24; k++) step(0, 1, 5'd5, 0, 1, 0, 5'd5, 1, 0);
        check("stall_cnt_sat", 32'(sc0), 15);
        idle();
        check("watchdog_sticky", 32'(e0), 1);

        // Reset in the middle of a stall
        writer5();
        reader5(0, 0);
        reader5(1, 0);
        check("rst_mid_stall", 32'(obs0), 0);
        reader5(0, 0);
        check("post_rst_issue", 32'(obs0), 0);
        check("post_rst_stall_cnt", 32'(sc0), 0);
        check("post_rst_watchdog", 32'(e0), 0);

        // Random traffic over a small register set
        for (int k = 0; k < 600; k++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
                 1'($urandom), 1'($urandom), 5'($urandom_range(0, 4)), 1'($urandom),
                 $urandom_range(0, 11) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
